// File: rtl/dx_pipe_reg_pkg.sv
// Shared decode constants for the D/X latch and the bypass unit.
// Provides opcode/aluop encodings, the NOP word, instruction field
// positions, the mult/div FSM state type and small helper functions.
package dx_pipe_reg_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  // Opcode field encodings
  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;

  // ALU sub-operation encodings (valid when opcode == OP_ALU)
  localparam logic [4:0] ALUOP_MUL = 5'b00110;
  localparam logic [4:0] ALUOP_DIV = 5'b00111;

  localparam logic [DATA_W-1:0] NOP = 32'h0000_0000;

  // Instruction field bit positions
  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 27;
  localparam int RD_HI     = 26;
  localparam int RD_LO     = 22;
  localparam int RS_HI     = 21;
  localparam int RS_LO     = 17;
  localparam int RT_HI     = 16;
  localparam int RT_LO     = 12;
  localparam int SHAMT_HI  = 11;
  localparam int SHAMT_LO  = 7;
  localparam int ALUOP_HI  = 6;
  localparam int ALUOP_LO  = 2;

  typedef enum logic {
    IDLE    = 1'b0,
    MD_WAIT = 1'b1
  } md_state_e;

  // True for an ALU-format multiply or divide
  function automatic logic is_muldiv(input logic [DATA_W-1:0] insn);
    logic [4:0] op;
    logic [4:0] aop;
    op  = insn[OPCODE_HI:OPCODE_LO];
    aop = insn[ALUOP_HI:ALUOP_LO];
    return (op == OP_ALU) && ((aop == ALUOP_MUL) || (aop == ALUOP_DIV));
  endfunction

  // Increment that sticks at all-ones
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dffe_clr32.sv
// 32-bit register with synchronous clear and load enable.
// Ports: clock, clr (clear to zero, wins over en), en (load d), d, q.
module dffe_clr32
  import dx_pipe_reg_pkg::*;
(
  input  logic              clock,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clock) begin
    if (clr)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/dx_pipe_reg.sv
// D/X pipeline latch with hazard control.
// Captures PC, instruction and both register operands from F/D, inserts
// bubbles for load-use stalls and flushes, and holds the latch while a
// multiply/divide is in flight (IDLE/MD_WAIT FSM).
// Ports:
//   clock, reset                 clock and synchronous active-high reset
//   fd_pc, fd_insn, rf_a, rf_b   incoming instruction and operands
//   ld_stall, flush, md_rdy      hazard/control requests
//   dx_pc, dx_insn, dx_a, dx_b   latched contents; dx_valid = not a bubble
//   dx_opcode/rd/rs/rt           decoded fields of dx_insn for bypassing
//   md_start                     one-cycle start pulse to mult/div unit
//   pc_we, fd_we                 front-end write enables (combinational)
//   bubble_cnt                   saturating stall/hold cycle counter
module dx_pipe_reg
  import dx_pipe_reg_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] fd_pc,
  input  logic [DATA_W-1:0] fd_insn,
  input  logic [DATA_W-1:0] rf_a,
  input  logic [DATA_W-1:0] rf_b,
  input  logic              ld_stall,
  input  logic              flush,
  input  logic              md_rdy,
  output logic [DATA_W-1:0] dx_pc,
  output logic [DATA_W-1:0] dx_insn,
  output logic [DATA_W-1:0] dx_a,
  output logic [DATA_W-1:0] dx_b,
  output logic [4:0]        dx_opcode,
  output logic [4:0]        dx_rd,
  output logic [4:0]        dx_rs,
  output logic [4:0]        dx_rt,
  output logic              dx_valid,
  output logic              md_start,
  output logic              pc_we,
  output logic              fd_we,
  output logic [CNT_W-1:0]  bubble_cnt
);

  md_state_e        state_q, state_d;
  logic             lat_clr, lat_en, cnt_inc, md_trig;
  logic [CNT_W-1:0] cnt_q;

  // Only a valid mul/div seen from IDLE starts the unit, so a held
  // instruction cannot fire a second start pulse.
  assign md_trig = (state_q == IDLE) && dx_valid && is_muldiv(dx_insn);

  always_comb begin
    state_d  = state_q;
    lat_clr  = 1'b0;
    lat_en   = 1'b0;
    cnt_inc  = 1'b0;
    md_start = 1'b0;
    pc_we    = 1'b1;
    fd_we    = 1'b1;
    if (reset) begin
      lat_clr = 1'b1;
      state_d = IDLE;
    end else if (flush) begin
      // Flush bubble: front end keeps moving, not counted
      lat_clr = 1'b1;
      state_d = IDLE;
    end else if (md_trig) begin
      // Launch cycle: mul/div stays in D/X
      md_start = 1'b1;
      pc_we    = 1'b0;
      fd_we    = 1'b0;
      state_d  = MD_WAIT;
    end else if ((state_q == MD_WAIT) && !md_rdy) begin
      pc_we   = 1'b0;
      fd_we   = 1'b0;
      cnt_inc = 1'b1;
    end else begin
      // Completion cycle still counts as a wait cycle, then the
      // pipeline resumes (a load-use stall may still apply).
      if (state_q == MD_WAIT) begin
        cnt_inc = 1'b1;
        state_d = IDLE;
      end
      if (ld_stall) begin
        lat_clr = 1'b1;
        pc_we   = 1'b0;
        fd_we   = 1'b0;
        cnt_inc = 1'b1;
      end else begin
        lat_en = 1'b1;
      end
    end
  end

  // D/X latch
  dffe_clr32 u_pc   (.clock(clock), .clr(lat_clr), .en(lat_en), .d(fd_pc),   .q(dx_pc));
  dffe_clr32 u_insn (.clock(clock), .clr(lat_clr), .en(lat_en), .d(fd_insn), .q(dx_insn));
  dffe_clr32 u_a    (.clock(clock), .clr(lat_clr), .en(lat_en), .d(rf_a),    .q(dx_a));
  dffe_clr32 u_b    (.clock(clock), .clr(lat_clr), .en(lat_en), .d(rf_b),    .q(dx_b));

  always_ff @(posedge clock) begin
    if (lat_clr)
      dx_valid <= 1'b0;
    else if (lat_en)
      dx_valid <= 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (cnt_inc)
        cnt_q <= sat_inc(cnt_q);
    end
  end

  assign bubble_cnt = cnt_q;
  assign dx_opcode  = dx_insn[OPCODE_HI:OPCODE_LO];
  assign dx_rd      = dx_insn[RD_HI:RD_LO];
  assign dx_rs      = dx_insn[RS_HI:RS_LO];
  assign dx_rt      = dx_insn[RT_HI:RT_LO];

endmodule

// File: tb/tb_dx_pipe_reg.sv
// Bench for dx_pipe_reg: directed scenarios followed by random traffic,
// every cycle compared against a cycle-level behavioural model.
module tb_dx_pipe_reg;

  logic        clock = 1'b0;
  logic        reset, ld_stall, flush, md_rdy;
  logic [31:0] fd_pc, fd_insn, rf_a, rf_b;
  logic [31:0] dx_pc, dx_insn, dx_a, dx_b;
  logic [4:0]  dx_opcode, dx_rd, dx_rs, dx_rt;
  logic        dx_valid, md_start, pc_we, fd_we;
  logic [15:0] bubble_cnt;

  int errors = 0;
  int checks = 0;
  int starts = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_insn, m_a, m_b;
  logic        m_valid, m_busy;
  logic [15:0] m_cnt;

  always #5 clock = ~clock;

  dx_pipe_reg dut (
    .clock(clock), .reset(reset), .fd_pc(fd_pc), .fd_insn(fd_insn),
    .rf_a(rf_a), .rf_b(rf_b), .ld_stall(ld_stall), .flush(flush),
    .md_rdy(md_rdy), .dx_pc(dx_pc), .dx_insn(dx_insn), .dx_a(dx_a),
    .dx_b(dx_b), .dx_opcode(dx_opcode), .dx_rd(dx_rd), .dx_rs(dx_rs),
    .dx_rt(dx_rt), .dx_valid(dx_valid), .md_start(md_start),
    .pc_we(pc_we), .fd_we(fd_we), .bubble_cnt(bubble_cnt)
  );

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] aop);
    return {op, rd, rs, rt, 5'd0, aop, 2'b00};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check combinational outputs against the
  // model, clock, advance the model, check the latch.
  task automatic cycle(input logic rst, input logic fl, input logic ls, input logic mr,
                       input logic [31:0] pc, input logic [31:0] insn,
                       input logic [31:0] a, input logic [31:0] b);
    logic muldiv, e_we, e_start;
    @(negedge clock);
    reset = rst; flush = fl; ld_stall = ls; md_rdy = mr;
    fd_pc = pc; fd_insn = insn; rf_a = a; rf_b = b;
    #1;
    muldiv  = m_valid && !m_busy && (m_insn[31:27] == 5'd0) &&
              (m_insn[6:2] == 5'd6 || m_insn[6:2] == 5'd7);
    e_start = !rst && !fl && muldiv;
    if (rst || fl)                 e_we = 1'b1;
    else if (muldiv)               e_we = 1'b0;
    else if (m_busy && !mr)        e_we = 1'b0;
    else                           e_we = !ls;
    chk("pc_we", {31'd0, pc_we}, {31'd0, e_we});
    chk("fd_we", {31'd0, fd_we}, {31'd0, e_we});
    chk("md_start", {31'd0, md_start}, {31'd0, e_start});
    if (md_start === 1'b1) starts++;
    @(posedge clock);
    if (rst) begin
      {m_pc, m_insn, m_a, m_b} = '0; m_valid = 0; m_busy = 0; m_cnt = 0;
    end else if (fl) begin
      {m_pc, m_insn, m_a, m_b} = '0; m_valid = 0; m_busy = 0;
    end else if (muldiv) begin
      m_busy = 1;
    end else if (m_busy && !mr) begin
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
    end else begin
      if (m_busy || ls) begin
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
      end
      m_busy = 0;
      if (ls) begin
        {m_pc, m_insn, m_a, m_b} = '0; m_valid = 0;
      end else begin
        m_pc = pc; m_insn = insn; m_a = a; m_b = b; m_valid = 1;
      end
    end
    #1;
    chk("dx_pc", dx_pc, m_pc);
    chk("dx_insn", dx_insn, m_insn);
    chk("dx_a", dx_a, m_a);
    chk("dx_b", dx_b, m_b);
    chk("dx_valid", {31'd0, dx_valid}, {31'd0, m_valid});
    chk("bubble_cnt", {16'd0, bubble_cnt}, {16'd0, m_cnt});
    chk("dx_fields", {12'd0, dx_opcode, dx_rd, dx_rs, dx_rt},
        {12'd0, m_insn[31:27], m_insn[26:22], m_insn[21:17], m_insn[16:12]});
  endtask

  task automatic idle_cycle(input logic [31:0] insn);
    cycle(0, 0, 0, 0, 32'h100, insn, 32'h11, 32'h22);
  endtask

  initial begin
    logic [31:0] lw_i, add_i, mul_i, nxt_i, ri;
    logic [15:0] c0;
    int s0;
    m_pc = '0; m_insn = '0; m_a = '0; m_b = '0; m_valid = 0; m_busy = 0; m_cnt = 0;
    reset = 1; flush = 0; ld_stall = 0; md_rdy = 0;
    fd_pc = 32'h40; fd_insn = 32'hFFFF_FFFF; rf_a = 32'h5; rf_b = 32'h6;
    lw_i  = mk(5'b01000, 5'd3, 5'd2, 5'd0, 5'd0);
    add_i = mk(5'b00000, 5'd4, 5'd3, 5'd1, 5'd0);
    mul_i = mk(5'b00000, 5'd5, 5'd1, 5'd2, 5'd6);
    nxt_i = mk(5'b00101, 5'd7, 5'd1, 5'd0, 5'd0);

    // Reset held two cycles
    cycle(1, 0, 0, 0, 32'h40, 32'hFFFF_FFFF, 32'h5, 32'h6);
    cycle(1, 0, 0, 0, 32'h40, 32'hFFFF_FFFF, 32'h5, 32'h6);
    chk("rst_valid", {31'd0, dx_valid}, 32'd0);
    chk("rst_insn", dx_insn, 32'd0);
    chk("rst_cnt", {16'd0, bubble_cnt}, 32'd0);

    // Load-use: lw, then add stalled one cycle
    cycle(0, 0, 0, 0, 32'h200, lw_i, 32'h1, 32'h2);
    chk("lu_lw", dx_insn, lw_i);
    cycle(0, 0, 1, 0, 32'h204, add_i, 32'h3, 32'h4);
    chk("lu_bubble", {31'd0, dx_valid}, 32'd0);
    cycle(0, 0, 0, 0, 32'h204, add_i, 32'h3, 32'h4);
    chk("lu_add", dx_insn, add_i);
    chk("lu_cnt", {16'd0, bubble_cnt}, 32'd1);

    // Mul: start pulse, four holds, md_rdy on the fifth wait cycle
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    s0 = starts;
    cycle(0, 0, 0, 0, 32'h300, mul_i, 32'h7, 32'h8);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 32'h304, nxt_i, 32'h9, 32'hA);
    chk("mul_held", dx_insn, mul_i);
    cycle(0, 0, 0, 1, 32'h304, nxt_i, 32'h9, 32'hA);
    chk("mul_cnt", {16'd0, bubble_cnt}, 32'd5);
    chk("mul_next", dx_insn, nxt_i);
    chk("mul_starts", starts - s0, 32'd1);

    // md_rdy while idle is ignored
    cycle(0, 0, 0, 1, 32'h308, add_i, 32'h1, 32'h1);
    chk("rdy_idle_cnt", {16'd0, bubble_cnt}, 32'd5);

    // Flush together with ld_stall
    c0 = bubble_cnt;
    cycle(0, 1, 1, 0, 32'h30C, add_i, 32'h1, 32'h1);
    chk("fl_valid", {31'd0, dx_valid}, 32'd0);
    chk("fl_cnt", {16'd0, bubble_cnt}, {16'd0, c0});

    // Flush during MD_WAIT
    cycle(0, 0, 0, 0, 32'h400, mul_i, 32'h1, 32'h2);
    cycle(0, 0, 0, 0, 32'h404, nxt_i, 32'h3, 32'h4);
    cycle(0, 0, 0, 0, 32'h404, nxt_i, 32'h3, 32'h4);
    s0 = starts;
    cycle(0, 1, 0, 0, 32'h404, nxt_i, 32'h3, 32'h4);
    chk("flmd_valid", {31'd0, dx_valid}, 32'd0);
    for (int i = 0; i < 3; i++) idle_cycle(32'h0);
    chk("flmd_starts", starts - s0, 32'd0);

    // Saturation: reach 16'hFFFE by stalling, then three more stalls
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65534; i++) cycle(0, 0, 1, 0, 32'h500, add_i, 32'h1, 32'h2);
    chk("sat_pre", {16'd0, bubble_cnt}, 32'h0000_FFFE);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 32'h500, add_i, 32'h1, 32'h2);
    chk("sat_cnt", {16'd0, bubble_cnt}, 32'h0000_FFFF);

    // Random traffic
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) < 3)
        ri = mk(5'd0, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom_range(6, 7)));
      else
        ri = $urandom;
      cycle($urandom_range(0, 99) < 2, $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) < 2, $urandom_range(0, 3) == 0,
            $urandom, ri, $urandom, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dx_pipe_reg.md
DX_PIPE_REG -- requirements
Module: dx_pipe_reg

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: one clock; reset is synchronous and active-high.
REQ-002 clock  in  1  pipeline clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 fd_pc  in  32  PC of instruction in the F/D latch.
REQ-005 fd_insn  in  32  instruction in the F/D latch. Fields: opcode[31:27], rd[26:22], rs[21:17], rt[16:12], shamt[11:7], aluop[6:2].
REQ-006 rf_a, rf_b  in  32 each  register-file read data for the decoding instruction.
REQ-007 ld_stall  in  1  load-use stall request from the X/W bypass unit.
REQ-008 flush  in  1  taken branch/jump resolved in X; squash younger instructions.
REQ-009 md_rdy  in  1  multiply/divide result ready, one-cycle pulse.
REQ-010 dx_pc, dx_insn, dx_a, dx_b  out  32 each  registered D/X latch contents.
REQ-011 dx_opcode, dx_rd, dx_rs, dx_rt  out  5 each  fields of dx_insn, combinational from the latch, fed to the bypass unit.
REQ-012 dx_valid  out  1  latch holds a real instruction (0 = bubble).
REQ-013 md_start  out  1  one-cycle start pulse to the mult/div unit.
REQ-014 pc_we, fd_we  out  1 each  write enables for the PC and the F/D latch.
REQ-015 bubble_cnt  out  16  saturating count of inserted bubble and hold cycles.

Function
REQ-016 NOP SHALL be 32'h0000_0000; a bubble loads dx_insn=NOP, dx_pc=0, dx_a=0, dx_b=0, dx_valid=0.
REQ-017 Priority per cycle SHALL be reset > flush > md hold > ld_stall > normal advance.
REQ-018 Normal advance: latch loads fd_pc/fd_insn/rf_a/rf_b with dx_valid=1, and pc_we=1, fd_we=1.
REQ-019 ld_stall=1 (no flush, no md hold): insert a bubble with pc_we=0 and fd_we=0; each consecutive stall cycle inserts another bubble.
REQ-020 flush=1: insert a bubble with pc_we=1 and fd_we=1, overriding ld_stall and md hold, and return the FSM to IDLE.
REQ-021 FSM SHALL have states IDLE and MD_WAIT.
REQ-022 IDLE->MD_WAIT when dx_valid=1, dx_opcode=00000, and aluop is 00110 (mul) or 00111 (div); md_start SHALL be 1 for exactly that cycle.
REQ-023 In MD_WAIT, the latch holds its contents and pc_we=fd_we=0.
REQ-024 MD_WAIT->IDLE on md_rdy=1; that cycle the pipeline advances normally (REQ-018).
REQ-025 A mul/div instruction SHALL NOT retrigger md_start while it is held.
REQ-026 md_rdy in IDLE SHALL be ignored.
REQ-027 bubble_cnt SHALL increment by 1 on every ld_stall bubble cycle and every MD_WAIT cycle, saturating at 16'hFFFF.
REQ-028 Flush bubbles SHALL NOT be counted in bubble_cnt.
REQ-029 pc_we and fd_we SHALL be combinational from the current state and inputs, with zero latency; latch outputs SHALL have one-cycle latency.

Reset
REQ-030 On reset=1 at a clock edge: latch = bubble, FSM = IDLE, bubble_cnt = 0, md_start = 0.
REQ-031 While reset=1, pc_we=1 and fd_we=1.
REQ-032 Reset asserted during MD_WAIT SHALL abandon the operation without issuing md_start.

Structure
REQ-033 Opcode constants (ALU 00000, ADDI 00101, SW 00111, LW 01000), aluop constants (MUL 00110, DIV 00111), NOP and field bit positions SHALL live in a shared package/constants file used with the bypass unit.
REQ-034 The 32-bit enable/clear register SHALL be one sub-module, dffe_clr32, instantiated four times.

Verification
REQ-035 Reset: hold reset=1 two cycles -> dx_valid=0, dx_insn=0, bubble_cnt=0, pc_we=fd_we=1.
REQ-036 Load-use: fd_insn=lw r3 then add r4,r3,r1 with ld_stall=1 one cycle -> one bubble, pc_we=fd_we=0 that cycle, add reaches D/X next cycle, bubble_cnt=1.
REQ-037 Mul: dx_insn = mul r5,r1,r2 -> md_start pulses once, hold 4 cycles, md_rdy on the 5th -> bubble_cnt=5, next instruction advances the cycle after md_rdy.
REQ-038 Flush and ld_stall together: flush=1, ld_stall=1 -> bubble inserted, pc_we=fd_we=1, bubble_cnt unchanged.
REQ-039 Flush in MD_WAIT: FSM returns to IDLE, dx_valid=0, no further md_start.
REQ-040 Saturation: preload 16'hFFFE, apply 3 stall cycles -> bubble_cnt=16'hFFFF.
